// File: rtl/serial_add_engine.sv
// serial_add_engine: bit-serial WIDTH-bit adder with valid/ready operand and result handshakes
module serial_add_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [CW-1:0] cnt;
  logic c, s, c_next, last;
  assign s = a_sh[0] ^ b_sh[0] ^ c;
  assign c_next = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
  assign last = cnt == CW'(WIDTH - 1);
  assign in_ready = state == IDLE;
  assign busy = state == BUSY;
  assign out_valid = state == DONE;
  // Accept operands, add one bit per cycle LSB first, then hold the result until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      c <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_sh <= a;
      b_sh <= b;
      c <= cin;
      cnt <= '0;
      state <= BUSY;
    end else if (state == BUSY) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= {s, r_sh[WIDTH-1:1]};
      c <= c_next;
      cnt <= cnt + 1'b1;
      if (last) begin
        state <= DONE;
        sum <= {s, r_sh[WIDTH-1:1]};
        cout <= c_next;
        ovf <= c ^ c_next;
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule
